// File: rtl/ds_rate_controller.sv
// ds_rate_controller
//   Sample-rate scheduler in front of the DeltaSigma modulator. Samples from
//   the interpolator/FIR chain are buffered in a small FIFO. A modulator
//   clock-enable strobe is generated every CLK_DIV clocks. Each sample is held
//   on mod_data for OSR strobes. The block also handles start-up priming,
//   underrun muting and the one-cycle clear of the modulator accumulators.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   enable        in   run request (level); dropping it flushes and idles
//   in_data       in   DW-bit two's complement input sample
//   in_valid      in   in_data valid
//   in_ready      out  FIFO can accept (combinational, level != FIFO_DEPTH)
//   mod_ce        out  modulator clock-enable, one-cycle strobe (registered)
//   mod_data      out  sample presented to the modulator (registered)
//   mod_rst       out  one-cycle clear of modulator accumulators/feedback
//   underrun      out  sticky flag: FIFO empty at a sample boundary
//   underrun_clr  in   clears underrun (a same-cycle set takes priority)
//   state         out  00 IDLE, 01 PRIME, 10 RUN, 11 MUTE
//   fifo_level    out  number of FIFO entries held
module ds_rate_controller #(
  parameter int DW         = 14,
  parameter int OSR        = 64,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic signed [DW-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          mod_ce,
  output logic signed [DW-1:0]          mod_data,
  output logic                          mod_rst,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic [1:0]                    state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int OSR_W = $clog2(OSR);

  localparam logic [LW-1:0]    PRIME_LVL = LW'(FIFO_DEPTH / 2);
  localparam logic [LW-1:0]    FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [OSR_W-1:0] OSR_LAST  = OSR_W'(OSR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PRIME = 2'b01,
    S_RUN   = 2'b10,
    S_MUTE  = 2'b11
  } state_t;

  state_t cur_state, nxt_state;

  // FIFO storage and bookkeeping
  logic signed [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;

  // Tick generation
  logic [DIV_W-1:0]     div_cnt;
  logic [OSR_W-1:0]     osr_cnt;

  // Decoded controls from the output process
  logic active;       // RUN or MUTE: counters run
  logic drop;         // enable removed while not idle
  logic tick;         // next edge produces a modulator strobe
  logic boundary;     // that strobe starts a new sample
  logic primed;
  logic have_data;
  logic push;
  logic pop;
  logic set_underrun;
  logic start;
  logic signed [DW-1:0] head;

  assign state      = cur_state;
  assign fifo_level = level;
  assign in_ready   = (level != FULL_LVL);
  assign head       = mem[rd_ptr];

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  // FSM: next-state logic
  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      S_IDLE:  if (enable) nxt_state = S_PRIME;
      S_PRIME: begin
        if (!enable)     nxt_state = S_IDLE;
        else if (primed) nxt_state = S_RUN;
      end
      S_RUN: begin
        if (!enable)           nxt_state = S_IDLE;
        else if (set_underrun) nxt_state = S_MUTE;
      end
      S_MUTE: begin
        if (!enable)  nxt_state = S_IDLE;
        else if (pop) nxt_state = S_RUN;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // FSM: output / control decode
  always_comb begin
    active       = 1'b0;
    drop         = 1'b0;
    tick         = 1'b0;
    boundary     = 1'b0;
    pop          = 1'b0;
    set_underrun = 1'b0;
    start        = 1'b0;
    primed       = (level >= PRIME_LVL);
    have_data    = (level != '0);
    active       = (cur_state == S_RUN) || (cur_state == S_MUTE);
    drop         = (cur_state != S_IDLE) && !enable;
    start        = (cur_state == S_IDLE) && enable;
    tick         = active && enable && (div_cnt == DIV_LAST);
    boundary     = tick && (osr_cnt == '0);
    // RUN pops whatever is there; MUTE waits until the FIFO is re-primed so
    // a trickle of samples cannot toggle between RUN and MUTE every sample.
    pop          = boundary && (((cur_state == S_RUN) && have_data) ||
                                ((cur_state == S_MUTE) && primed));
    set_underrun = boundary && (cur_state == S_RUN) && !have_data;
    push         = in_valid && in_ready && !drop;
  end

  // Stage p0: tick counters (held at zero outside RUN/MUTE so the first
  // strobe lands exactly CLK_DIV cycles after entering RUN)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      osr_cnt <= '0;
    end else if (!active || drop) begin
      div_cnt <= '0;
      osr_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (tick) osr_cnt <= (osr_cnt == OSR_LAST) ? '0 : osr_cnt + 1'b1;
    end
  end

  // FIFO storage: contents need no reset, pointers and level qualify them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (drop) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Stage p1: modulator-facing registers; mod_data and the boundary strobe
  // change on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mod_ce   <= 1'b0;
      mod_rst  <= 1'b0;
      mod_data <= '0;
      underrun <= 1'b0;
    end else begin
      mod_ce  <= tick;
      mod_rst <= start;
      if (drop || (cur_state == S_IDLE)) mod_data <= '0;
      else if (boundary)                 mod_data <= pop ? head : '0;
      if (set_underrun)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ds_rate_controller.sv
// Directed bench for ds_rate_controller with DW=14, OSR=4, CLK_DIV=4,
// FIFO_DEPTH=4. Inputs are driven and outputs sampled 1 time unit after
// each rising clock edge.
module tb_ds_rate_controller;

  localparam int DW = 14;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mod_ce;
  logic signed [DW-1:0] mod_data;
  logic                 mod_rst;
  logic                 underrun;
  logic                 underrun_clr;
  logic [1:0]           state;
  logic [2:0]           fifo_level;

  int total = 0;
  int bad   = 0;

  ds_rate_controller #(
    .DW(DW), .OSR(4), .CLK_DIV(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mod_ce(mod_ce),
    .mod_data(mod_data),
    .mod_rst(mod_rst),
    .underrun(underrun),
    .underrun_clr(underrun_clr),
    .state(state),
    .fifo_level(fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Three quiet cycles between strobes
  task automatic pre3(input string tag);
    for (int i = 0; i < 3; i++) begin
      step();
      check({tag, "_ce_lo"}, mod_ce, 0);
    end
  endtask

  task automatic next_strobe(input string tag, input int exp_data);
    pre3(tag);
    step();
    check({tag, "_ce_hi"}, mod_ce, 1);
    check({tag, "_data"}, mod_data, exp_data);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_data = '0; in_valid = 1'b0;
    underrun_clr = 1'b0;
    step(); step();

    // Reset values
    check("rst_state", state, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", in_ready, 1);
    check("rst_ce", mod_ce, 0);
    check("rst_data", mod_data, 0);
    check("rst_mrst", mod_rst, 0);
    check("rst_unrun", underrun, 0);
    reset = 1'b0;

    // Fill FIFO while idle: full at 4, fifth push ignored
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 14'(i);
      step();
      check("fill_level", fifo_level, i);
    end
    check("full_ready", in_ready, 0);
    in_data = 14'sd55;
    step();
    check("full_level5", fifo_level, 4);
    check("full_state", state, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("flush_level", fifo_level, 0);
    reset = 1'b0;
    step();

    // Start-up: prime with 100, 200
    enable = 1'b1; in_valid = 1'b1; in_data = 14'sd100;
    step();
    check("t1_mrst_hi", mod_rst, 1);
    check("t1_prime", state, 1);
    check("t1_level1", fifo_level, 1);
    in_data = 14'sd200;
    step();
    check("t1_mrst_lo", mod_rst, 0);
    check("t1_still_prime", state, 1);
    check("t1_level2", fifo_level, 2);
    in_valid = 1'b0;
    step();
    check("t1_run", state, 2);
    check("t1_data0", mod_data, 0);
    next_strobe("t1_s1", 100);
    check("t1_lvl_after_pop", fifo_level, 1);
    for (int i = 0; i < 3; i++) next_strobe("t1_hold100", 100);
    next_strobe("t1_s5", 200);
    check("t1_lvl_empty", fifo_level, 0);
    for (int i = 0; i < 3; i++) next_strobe("t1_hold200", 200);

    // Underrun at next boundary -> MUTE, strobes continue
    next_strobe("t3_ur", 0);
    check("t3_underrun", underrun, 1);
    check("t3_mute", state, 3);
    in_valid = 1'b1; in_data = 14'sd300;
    step();
    check("t3_gap1", mod_ce, 0);
    in_data = 14'sd400;
    step();
    check("t3_gap2", mod_ce, 0);
    check("t3_level2", fifo_level, 2);
    in_valid = 1'b0;
    step();
    step();
    check("t3_mute_ce", mod_ce, 1);
    check("t3_mute_data", mod_data, 0);
    check("t3_mute_state", state, 3);
    next_strobe("t3_mute_s2", 0);
    next_strobe("t3_mute_s3", 0);
    next_strobe("t3_resume", 300);
    check("t3_run_again", state, 2);
    check("t3_level1", fifo_level, 1);
    check("t3_sticky", underrun, 1);

    // Push concurrent with boundary pop at level 2
    in_valid = 1'b1; in_data = 14'sd500;
    step();
    in_valid = 1'b0;
    check("t5_level2", fifo_level, 2);
    step(); step(); step();
    check("t5_ce", mod_ce, 1);
    check("t5_hold300", mod_data, 300);
    next_strobe("t5_h1", 300);
    next_strobe("t5_h2", 300);
    pre3("t5_pre");
    in_valid = 1'b1; in_data = 14'sd600;
    step();
    in_valid = 1'b0;
    check("t5_ce_b", mod_ce, 1);
    check("t5_pop400", mod_data, 400);
    check("t5_level_kept", fifo_level, 2);
    for (int i = 0; i < 3; i++) next_strobe("t5_hold400", 400);
    next_strobe("t5_pop500", 500);
    check("t5_level_1", fifo_level, 1);
    for (int i = 0; i < 3; i++) next_strobe("t5_hold500", 500);
    next_strobe("t5_pop600", 600);
    check("t5_level_0", fifo_level, 0);

    // underrun_clr alone, then clr colliding with a new underrun
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("t4_clr_alone", underrun, 0);
    step(); step(); step();
    check("t4_ce", mod_ce, 1);
    check("t4_hold600", mod_data, 600);
    next_strobe("t4_h1", 600);
    next_strobe("t4_h2", 600);
    pre3("t4_pre");
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("t4_set_wins", underrun, 1);
    check("t4_mute", state, 3);
    check("t4_data0", mod_data, 0);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("t4_clr_after", underrun, 0);

    // Refill from MUTE, resume, then drop enable mid-sample
    in_valid = 1'b1; in_data = 14'sd800;
    step();
    in_data = 14'sd900;
    step();
    in_valid = 1'b0;
    step();
    check("t6_ce", mod_ce, 1);
    check("t6_mute", state, 3);
    next_strobe("t6_m1", 0);
    next_strobe("t6_m2", 0);
    next_strobe("t6_pop800", 800);
    check("t6_run", state, 2);
    step(); step();
    enable = 1'b0; in_valid = 1'b1; in_data = 14'sd700;
    step();
    in_valid = 1'b0;
    check("t6_drop_state", state, 0);
    check("t6_drop_level", fifo_level, 0);
    check("t6_drop_ce", mod_ce, 0);
    check("t6_drop_data", mod_data, 0);
    check("t6_drop_ready", in_ready, 1);

    // Restart, then async reset mid-RUN
    enable = 1'b1; in_valid = 1'b1; in_data = 14'sd11;
    step();
    in_data = 14'sd22;
    step();
    in_valid = 1'b0;
    step();
    check("t6_rerun", state, 2);
    next_strobe("t6_pop11", 11);
    step();
    reset = 1'b1;
    #1;
    check("t6_rst_state", state, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_ce", mod_ce, 0);
    check("t6_rst_data", mod_data, 0);
    check("t6_rst_ready", in_ready, 1);
    reset = 1'b0;
    enable = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
